// File: rtl/step_pkg.sv
// Shared definitions for the step pulse generator.
//   step_state_e     : controller state encoding
//   HOME_DIV_DEFAULT : default homing half-period, in sysclk cycles
//   ch_width()       : width of a channel index for n channels (at least 1)
package step_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_HOME_SEEK = 3'd1,
    ST_HOME_BACK = 3'd2,
    ST_RUN       = 3'd3,
    ST_FINISH    = 3'd4
  } step_state_e;

  localparam int HOME_DIV_DEFAULT = 3000000;

  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/step_timer.sv
// Per-step phase timer, shared by all channels (only one channel steps at a time).
// A step is a low phase of div_i cycles followed by a high phase of div_i cycles.
//   sysclk, rst_n : clock, async active-low reset
//   start_i       : restart at the beginning of a low phase (overrides en_i)
//   en_i          : advance the timer this cycle
//   div_i         : half-period in cycles (0 is treated as 1)
//   phase_o       : 0 = low phase, 1 = high phase
//   rise_o        : last cycle of a low phase (the output rises next cycle)
//   end_high_o    : last cycle of a high phase
module step_timer #(
  parameter int DIVW = 24
) (
  input  logic            sysclk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic            en_i,
  input  logic [DIVW-1:0] div_i,
  output logic            phase_o,
  output logic            rise_o,
  output logic            end_high_o
);

  logic [DIVW-1:0] cnt_q, cnt_d;
  logic            phase_q, phase_d;
  logic [DIVW-1:0] div_eff;
  logic [DIVW-1:0] reload;
  logic            tc;

  assign div_eff = (div_i == '0) ? DIVW'(1) : div_i;
  assign reload  = div_eff - DIVW'(1);
  assign tc      = (cnt_q == '0);

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (start_i) begin
      cnt_d   = reload;
      phase_d = 1'b0;
    end else if (en_i) begin
      if (tc) begin
        cnt_d   = reload;
        phase_d = ~phase_q;
      end else begin
        cnt_d = cnt_q - DIVW'(1);
      end
    end
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_o    = phase_q;
  assign rise_o     = en_i & ~start_i & tc & ~phase_q;
  assign end_high_o = en_i & ~start_i & tc &  phase_q;

endmodule

// File: rtl/step_pulse_gen.sv
// Multi-channel stepper pulse generator with homing sequence.
// One channel is active at a time; the others idle with pu=1, mf=0, dr=0.
//
//   state      | meaning
//   -----------+----------------------------------------------------------
//   IDLE       | waiting for home_start or a move command
//   HOME_SEEK  | stepping channel ch_q toward the switch (dr=0) until lim rises
//   HOME_BACK  | stepping channel ch_q away (dr=1) until lim falls, then homed
//   RUN        | issuing pulses_q steps on ch_q with half-period div_q
//   FINISH     | one-cycle done pulse, then back to IDLE
//
// Ports:
//   sysclk, rst_n           : clock, async active-low reset
//   home_start              : one-cycle request to home all channels (IDLE only)
//   cmd_valid/cmd_ready     : move command handshake (ready only when all homed)
//   cmd_ch/dir/pulses/div   : move target channel, direction, step count, half-period
//   abort                   : stop any activity, go through FINISH
//   lim                     : raw async limit switches, active-high
//   busy, done, err         : activity, one-cycle completion, sticky error
//   homed                   : per-channel homed flags
//   pu, mf, dr              : step (active-low), drive enable, direction per channel
module step_pulse_gen
  import step_pkg::*;
#(
  parameter  int NCH      = 6,
  parameter  int PCW      = 16,
  parameter  int DIVW     = 24,
  parameter  int HOME_DIV = HOME_DIV_DEFAULT,
  localparam int CHW      = ch_width(NCH)
) (
  input  logic            sysclk,
  input  logic            rst_n,
  input  logic            home_start,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [CHW-1:0]  cmd_ch,
  input  logic            cmd_dir,
  input  logic [PCW-1:0]  cmd_pulses,
  input  logic [DIVW-1:0] cmd_div,
  input  logic            abort,
  input  logic [NCH-1:0]  lim,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [NCH-1:0]  homed,
  output logic [NCH-1:0]  pu,
  output logic [NCH-1:0]  mf,
  output logic [NCH-1:0]  dr
);

  localparam logic [DIVW-1:0] HOME_DIV_W = DIVW'(HOME_DIV);
  localparam logic [CHW-1:0]  CH_LAST    = CHW'(NCH - 1);
  localparam logic [CHW:0]    NCH_W      = (CHW + 1)'(NCH);

  step_state_e     state_q, state_d;
  logic [CHW-1:0]  ch_q, ch_d;
  logic            dir_q, dir_d;
  logic [PCW-1:0]  pulses_q, pulses_d;
  logic [DIVW-1:0] div_q, div_d;
  logic [PCW-1:0]  step_cnt_q, step_cnt_d;
  logic [NCH-1:0]  homed_q, homed_d;
  logic            err_q, err_d;
  logic            lim_stop_q, lim_stop_d;

  logic [NCH-1:0]  lim_s1_q, lim_s2_q, lim_s3_q;
  logic [NCH-1:0]  lim_rise, lim_fall;
  logic [NCH-1:0]  ch_oh;
  logic            sel_rise, sel_fall;

  logic            tmr_start, tmr_en;
  logic [DIVW-1:0] tmr_div;
  logic            tmr_phase, tmr_rise, tmr_end_high;

  logic [DIVW-1:0] cmd_div_eff;
  logic            cmd_bad;
  logic            cmd_accept;
  logic            stepping;

  // Limit switch synchronizer; s3 is the one-cycle-delayed copy for edges.
  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      lim_s1_q <= '0;
      lim_s2_q <= '0;
      lim_s3_q <= '0;
    end else begin
      lim_s1_q <= lim;
      lim_s2_q <= lim_s1_q;
      lim_s3_q <= lim_s2_q;
    end
  end

  assign lim_rise = lim_s2_q & ~lim_s3_q;
  assign lim_fall = ~lim_s2_q & lim_s3_q;

  always_comb begin
    ch_oh = '0;
    for (int i = 0; i < NCH; i++) begin
      ch_oh[i] = (ch_q == CHW'(i));
    end
  end

  assign sel_rise = |(lim_rise & ch_oh);
  assign sel_fall = |(lim_fall & ch_oh);

  assign cmd_div_eff = (cmd_div == '0) ? DIVW'(1) : cmd_div;
  assign cmd_bad     = (cmd_pulses == '0) || ({1'b0, cmd_ch} >= NCH_W);
  // home_start wins over a simultaneous command, so ready drops with it.
  assign cmd_ready   = (state_q == ST_IDLE) && (&homed_q) && !home_start;
  assign cmd_accept  = cmd_valid && cmd_ready;
  assign stepping    = (state_q == ST_HOME_SEEK) || (state_q == ST_HOME_BACK) ||
                       (state_q == ST_RUN);
  assign tmr_en      = stepping;

  step_timer #(
    .DIVW (DIVW)
  ) u_timer (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .start_i    (tmr_start),
    .en_i       (tmr_en),
    .div_i      (tmr_div),
    .phase_o    (tmr_phase),
    .rise_o     (tmr_rise),
    .end_high_o (tmr_end_high)
  );

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    dir_d      = dir_q;
    pulses_d   = pulses_q;
    div_d      = div_q;
    step_cnt_d = step_cnt_q;
    homed_d    = homed_q;
    err_d      = err_q;
    lim_stop_d = lim_stop_q;
    tmr_start  = 1'b0;
    tmr_div    = div_q;

    unique case (state_q)
      ST_IDLE: begin
        lim_stop_d = 1'b0;
        if (home_start) begin
          homed_d   = '0;
          err_d     = 1'b0;
          ch_d      = '0;
          tmr_start = 1'b1;
          tmr_div   = HOME_DIV_W;
          state_d   = ST_HOME_SEEK;
        end else if (cmd_accept) begin
          ch_d       = cmd_ch;
          dir_d      = cmd_dir;
          pulses_d   = cmd_pulses;
          div_d      = cmd_div_eff;
          step_cnt_d = '0;
          if (cmd_bad) begin
            err_d   = 1'b1;
            state_d = ST_FINISH;
          end else begin
            err_d     = 1'b0;
            tmr_start = 1'b1;
            tmr_div   = cmd_div_eff;
            state_d   = ST_RUN;
          end
        end
      end

      ST_HOME_SEEK: begin
        tmr_div = HOME_DIV_W;
        if (abort) begin
          state_d = ST_FINISH;
        end else if (sel_rise) begin
          tmr_start = 1'b1;
          state_d   = ST_HOME_BACK;
        end
      end

      ST_HOME_BACK: begin
        tmr_div = HOME_DIV_W;
        if (abort) begin
          state_d = ST_FINISH;
        end else if (sel_fall) begin
          homed_d = homed_q | ch_oh;
          if (ch_q == CH_LAST) begin
            state_d = ST_FINISH;
          end else begin
            ch_d      = ch_q + CHW'(1);
            tmr_start = 1'b1;
            state_d   = ST_HOME_SEEK;
          end
        end
      end

      ST_RUN: begin
        tmr_div = div_q;
        if (tmr_rise) begin
          step_cnt_d = step_cnt_q + PCW'(1);
        end
        // A limit hit while moving toward the switch is remembered and
        // honoured at the end of the current high phase.
        if (!dir_q && sel_rise) begin
          lim_stop_d = 1'b1;
        end
        if (abort) begin
          state_d = ST_FINISH;
        end else if (step_cnt_q == pulses_q) begin
          state_d = ST_FINISH;
        end else if (tmr_end_high && (lim_stop_q || (!dir_q && sel_rise))) begin
          err_d   = 1'b1;
          homed_d = homed_q & ~ch_oh;
          state_d = ST_FINISH;
        end
      end

      ST_FINISH: begin
        lim_stop_d = 1'b0;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge sysclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      dir_q      <= 1'b0;
      pulses_q   <= '0;
      div_q      <= DIVW'(1);
      step_cnt_q <= '0;
      homed_q    <= '0;
      err_q      <= 1'b0;
      lim_stop_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      dir_q      <= dir_d;
      pulses_q   <= pulses_d;
      div_q      <= div_d;
      step_cnt_q <= step_cnt_d;
      homed_q    <= homed_d;
      err_q      <= err_d;
      lim_stop_q <= lim_stop_d;
    end
  end

  // Channel outputs decode from registered state only, so FINISH/IDLE and
  // reset immediately park every channel.
  always_comb begin
    pu = '1;
    mf = '0;
    dr = '0;
    if (stepping) begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_oh[i]) begin
          pu[i] = tmr_phase;
          mf[i] = 1'b1;
          dr[i] = (state_q == ST_RUN) ? dir_q : (state_q == ST_HOME_BACK);
        end
      end
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = (state_q == ST_FINISH);
  assign err   = err_q;
  assign homed = homed_q;

endmodule
